// File: rtl/exec_sequencer.sv
// exec_sequencer: single-issue sequencer that buffers arithmetic instructions,
// fetches both operands from the register file, hands them to the execution
// unit, waits for its result and writes that result back to the destination.
// Exactly one operation is in flight at any time.

module exec_sequencer #(
    parameter int WIDTH   = 8,
    parameter int SIZE    = 64,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 32,
    localparam int AW     = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,

    // instruction source
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_opcode,
    input  logic [AW-1:0]    in_dst,
    input  logic [AW-1:0]    in_src1,
    input  logic [AW-1:0]    in_src2,

    // register file
    output logic [AW-1:0]    rf_raddr1,
    output logic [AW-1:0]    rf_raddr2,
    input  logic [WIDTH-1:0] rf_rdata1,
    input  logic [WIDTH-1:0] rf_rdata2,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,

    // execution unit
    output logic             ex_enable,
    output logic [1:0]       ex_opcode,
    output logic [WIDTH-1:0] ex_src1,
    output logic [WIDTH-1:0] ex_src2,
    output logic [AW-1:0]    ex_dst_addr,
    input  logic             ex_ready,
    input  logic [WIDTH-1:0] ex_result,

    // status
    output logic             done,
    output logic             timeout_err,
    output logic             idle
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_NOP = 2'b00;

    typedef struct packed {
        logic [1:0]    opcode;
        logic [AW-1:0] dst;
        logic [AW-1:0] src1;
        logic [AW-1:0] src2;
    } instr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t          state;
    instr_t          cur;          // instruction currently being sequenced
    logic [TW-1:0]   wait_cnt;     // WAIT cycles completed for the current op

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    instr_t          fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    instr_t          in_instr;
    instr_t          head;

    assign in_instr = '{opcode: in_opcode, dst: in_dst, src1: in_src1, src2: in_src2};
    assign head     = fifo_mem[rd_ptr];

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = rst_n && !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && !empty;

    // Read addresses come straight from the latched instruction, so they are
    // valid throughout READ and the RF returns operands during ISSUE.
    assign rf_raddr1 = cur.src1;
    assign rf_raddr2 = cur.src2;

    assign idle = (state == S_IDLE) && empty;

    // FIFO storage write on every accepted instruction.
    // NOTE: the storage array is deliberately not reset; count and the
    // pointers define which entries are meaningful, so stale contents are
    // never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_instr;
        end
    end

    // FIFO pointers and occupancy; push and pop may happen in the same cycle.
    // NOTE: every register in a clocked block uses <= so all state updates
    // see the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencing FSM with registered outputs
    // ------------------------------------------------------------------

    // Walks each popped instruction through READ/ISSUE/WAIT/WRITE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cur         <= '0;
            wait_cnt    <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            ex_enable   <= 1'b0;
            ex_opcode   <= '0;
            ex_src1     <= '0;
            ex_src2     <= '0;
            ex_dst_addr <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Write strobe and completion pulse last a single cycle.
            rf_we <= 1'b0;
            done  <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        cur <= head;
                        // A NOP is consumed here and never leaves IDLE.
                        if (head.opcode != OP_NOP) begin
                            state <= S_READ;
                        end
                    end
                end

                S_READ: begin
                    state <= S_ISSUE;
                end

                S_ISSUE: begin
                    ex_src1     <= rf_rdata1;
                    ex_src2     <= rf_rdata2;
                    ex_opcode   <= cur.opcode;
                    ex_dst_addr <= cur.dst;
                    ex_enable   <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        // Final WAIT cycle: abandon even if ready shows up now.
                        timeout_err <= 1'b1;
                        ex_enable   <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        // The first WAIT cycle may still see the previous op's
                        // ready, so only later cycles accept a result.
                        if ((wait_cnt != '0) && ex_ready) begin
                            ex_enable <= 1'b0;
                            rf_we     <= 1'b1;
                            done      <= 1'b1;
                            rf_waddr  <= cur.dst;
                            rf_wdata  <= ex_result;
                            state     <= S_WRITE;
                        end
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end

                S_WRITE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed vector table, hand-written
// corner sequences, and a randomized run scored against an instruction-level
// model of the register file.

module tb_exec_sequencer;

    localparam int W  = 8;
    localparam int AW = 6;
    localparam int N  = 64;
    localparam int NV = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_opcode = '0;
    logic [AW-1:0] in_dst = '0;
    logic [AW-1:0] in_src1 = '0;
    logic [AW-1:0] in_src2 = '0;
    logic [AW-1:0] rf_raddr1, rf_raddr2;
    logic [W-1:0]  rf_rdata1 = '0, rf_rdata2 = '0;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [W-1:0]  rf_wdata;
    logic          ex_enable;
    logic [1:0]    ex_opcode;
    logic [W-1:0]  ex_src1, ex_src2;
    logic [AW-1:0] ex_dst_addr;
    logic          ex_ready = 1'b0;
    logic [W-1:0]  ex_result = '0;
    logic          done, timeout_err, idle;

    exec_sequencer #(.WIDTH(W), .SIZE(N), .DEPTH(4), .TIMEOUT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ex_enable(ex_enable), .ex_opcode(ex_opcode),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_dst_addr(ex_dst_addr),
        .ex_ready(ex_ready), .ex_result(ex_result),
        .done(done), .timeout_err(timeout_err), .idle(idle)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int n_done   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Arithmetic rules of the execution unit.
    function automatic logic [W-1:0] alu(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [15:0] p;
        case (op)
            2'b01:   begin p = 16'(a) * 16'(b); return p[W-1:0]; end
            2'b10:   return a + b;
            2'b11:   return a - b;
            default: return '0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Environment: register file and execution unit
    // ------------------------------------------------------------------
    logic [W-1:0]  rf_mem [N];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [W-1:0]  pl_data = '0;

    // Register file with one-cycle read latency; pl_* lets the bench preload.
    always @(posedge clk) begin
        rf_rdata1 <= rf_mem[rf_raddr1];
        rf_rdata2 <= rf_mem[rf_raddr2];
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        if (pl_en) rf_mem[pl_addr] <= pl_data;
    end

    int ex_lat    = 2;     // enable cycles before ready is raised
    bit ex_stuck  = 1'b0;  // ready permanently high
    int en_cycles = 0;

    // Execution unit: result is garbage during the first enabled cycle so a
    // premature capture shows up as wrong data.
    always @(negedge clk) begin
        if (ex_enable) en_cycles++;
        else           en_cycles = 0;
        ex_ready  = ex_stuck || (ex_enable && en_cycles >= ex_lat);
        ex_result = (en_cycles >= 2) ? alu(ex_opcode, ex_src1, ex_src2)
                                     : ~alu(ex_opcode, ex_src1, ex_src2);
    end

    // ------------------------------------------------------------------
    // Reference model: instruction-level register file and expected writes
    // ------------------------------------------------------------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;

    logic [W-1:0] ref_rf [N];
    wr_t          exp_q [$];
    wr_t          mon_e;

    // Writeback monitor: every write must match the next expected one.
    always @(negedge clk) begin
        if (rst_n && (rf_we || done)) begin
            check("done_with_we", done, rf_we);
            if (done) n_done++;
            if (rf_we) begin
                n_writes++;
                check("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("wb_addr", rf_waddr, mon_e.addr);
                    check("wb_data", rf_wdata, mon_e.data);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        ref_rf[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input logic [AW-1:0] d,
                        input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                        input bit will_write);
        int  w;
        wr_t e;
        w = 0;
        in_opcode = op;
        in_dst    = d;
        in_src1   = s1;
        in_src2   = s2;
        in_valid  = 1'b1;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("push_accepted", in_ready, 1);
        if (in_ready && will_write && op != 2'b00) begin
            e.addr = d;
            e.data = alu(op, ref_rf[s1], ref_rf[s2]);
            ref_rf[d] = e.data;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_we(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rf_we && cyc < 200);
        check("rf_we_seen", rf_we, 1);
    endtask

    task automatic wait_enable();
        int c;
        c = 0;
        while (!ex_enable && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("ex_enable_seen", ex_enable, 1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (!(idle && exp_q.size() == 0) && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check("idle_reached", idle, 1);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] dst;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic [W-1:0]  r1;
        logic [W-1:0]  r2;
        int            lat;
        logic [W-1:0]  exp_data;
        int            exp_lat;   // cycles from push edge to rf_we
    } vec_t;

    vec_t vecs [NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, cyc2, wb0, d0, n, mism;

        vecs[0] = '{2'b10, 6'd3,  6'd1,  6'd2,  8'd5,   8'd3,   2,  8'd8,   5};
        vecs[1] = '{2'b11, 6'd5,  6'd6,  6'd7,  8'd5,   8'd3,   2,  8'd2,   5};
        vecs[2] = '{2'b11, 6'd5,  6'd6,  6'd7,  8'd3,   8'd5,   3,  8'hFE,  6};
        vecs[3] = '{2'b01, 6'd4,  6'd1,  6'd2,  8'd5,   8'd3,   2,  8'd15,  5};
        vecs[4] = '{2'b01, 6'd8,  6'd9,  6'd10, 8'd16,  8'd16,  4,  8'h00,  7};
        vecs[5] = '{2'b10, 6'd11, 6'd12, 6'd13, 8'hFF,  8'h01,  2,  8'h00,  5};
        vecs[6] = '{2'b01, 6'd14, 6'd15, 6'd16, 8'h0F,  8'h11,  2,  8'hFF,  5};
        vecs[7] = '{2'b10, 6'd1,  6'd1,  6'd1,  8'd7,   8'd7,   2,  8'd14,  5};
        vecs[8] = '{2'b10, 6'd63, 6'd62, 6'd0,  8'd100, 8'd27,  1,  8'd127, 5};
        vecs[9] = '{2'b11, 6'd0,  6'd63, 6'd62, 8'd10,  8'd20,  31, 8'hF6,  34};

        // ---------------- reset ----------------
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 0);
        for (int i = 0; i < N; i++) preload(6'(i), 8'($urandom));
        check("rst_rf_we", rf_we, 0);
        check("rst_done", done, 0);
        check("rst_ex_enable", ex_enable, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_rf_raddr1", rf_raddr1, 0);
        check("rst_ex_src1", ex_src1, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_idle", idle, 1);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1);

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            ex_lat = vecs[i].lat;
            preload(vecs[i].s1, vecs[i].r1);
            preload(vecs[i].s2, vecs[i].r2);
            push(vecs[i].op, vecs[i].dst, vecs[i].s1, vecs[i].s2, 1'b1);
            wait_we(cyc);
            check($sformatf("vec%0d_waddr", i), rf_waddr, vecs[i].dst);
            check($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_data);
            check($sformatf("vec%0d_latency", i), cyc, vecs[i].exp_lat);
            check($sformatf("vec%0d_done", i), done, 1);
            wait_idle();
        end

        // ---------------- NOP then mul ----------------
        ex_lat = 2;
        preload(6'd1, 8'd5);
        preload(6'd2, 8'd3);
        wb0 = n_writes;
        d0  = n_done;
        push(2'b00, 6'd9, 6'd1, 6'd2, 1'b1);
        push(2'b01, 6'd4, 6'd1, 6'd2, 1'b1);
        wait_idle();
        check("nop_mul_writes", n_writes - wb0, 1);
        check("nop_mul_dones", n_done - d0, 1);
        check("nop_mul_r4", rf_mem[4], 15);

        // ---------------- back-to-back ----------------
        push(2'b10, 6'd20, 6'd1, 6'd2, 1'b1);
        push(2'b11, 6'd21, 6'd20, 6'd2, 1'b1);
        wait_we(cyc);
        wait_we(cyc2);
        check("back_to_back_gap", cyc2, 6);
        wait_idle();

        // ---------------- ready stuck high ----------------
        preload(6'd40, 8'h21);
        preload(6'd41, 8'h10);
        ex_stuck = 1'b1;
        push(2'b11, 6'd42, 6'd40, 6'd41, 1'b1);
        wait_we(cyc);
        check("stuck_ready_latency", cyc, 5);
        check("stuck_ready_wdata", rf_wdata, 8'h11);
        ex_stuck = 1'b0;
        wait_idle();

        // ---------------- timeout (ready only in the 32nd WAIT cycle) ----------------
        ex_lat = 32;
        wb0 = n_writes;
        push(2'b10, 6'd22, 6'd1, 6'd2, 1'b0);
        wait_enable();
        n = 0;
        while (ex_enable && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("timeout_wait_cycles", n, 32);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_idle", idle, 1);
        check("timeout_no_write", n_writes - wb0, 0);
        ex_lat = 2;
        push(2'b10, 6'd23, 6'd1, 6'd2, 1'b1);
        wait_we(cyc);
        check("after_timeout_latency", cyc, 5);
        check("timeout_err_sticky", timeout_err, 1);
        wait_idle();

        // ---------------- FIFO fill while stalled ----------------
        ex_lat = 20;
        wb0 = n_writes;
        push(2'b10, 6'd30, 6'd31, 6'd32, 1'b1);
        wait_enable();
        push(2'b11, 6'd33, 6'd30, 6'd31, 1'b1);
        push(2'b01, 6'd34, 6'd33, 6'd30, 1'b1);
        push(2'b11, 6'd35, 6'd34, 6'd33, 1'b1);
        check("in_ready_after_3", in_ready, 1);
        push(2'b10, 6'd36, 6'd35, 6'd34, 1'b1);
        check("in_ready_after_4", in_ready, 0);
        push(2'b11, 6'd37, 6'd36, 6'd35, 1'b1);
        wait_idle();
        check("fifo_fill_writes", n_writes - wb0, 6);

        // ---------------- reset during WAIT with entries queued ----------------
        push(2'b10, 6'd50, 6'd51, 6'd52, 1'b0);
        wait_enable();
        push(2'b01, 6'd53, 6'd51, 6'd52, 1'b0);
        push(2'b11, 6'd54, 6'd51, 6'd52, 1'b0);
        wb0 = n_writes;
        rst_n = 1'b0;
        #1;
        check("in_ready_during_reset", in_ready, 0);
        @(negedge clk);
        check("mid_reset_ex_enable", ex_enable, 0);
        check("mid_reset_rf_we", rf_we, 0);
        check("mid_reset_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        #1;
        check("mid_reset_idle", idle, 1);
        check("mid_reset_in_ready", in_ready, 1);
        repeat (40) @(negedge clk);
        check("mid_reset_no_write", n_writes - wb0, 0);
        ex_lat = 2;
        push(2'b10, 6'd55, 6'd1, 6'd2, 1'b1);
        wait_we(cyc);
        check("after_reset_latency", cyc, 5);
        wait_idle();

        // ---------------- randomized run ----------------
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ex_lat = $urandom_range(1, 20);
            push(2'($urandom_range(0, 3)), 6'($urandom_range(0, N - 1)),
                 6'($urandom_range(0, N - 1)), 6'($urandom_range(0, N - 1)), 1'b1);
        end
        wait_idle();
        mism = 0;
        for (int i = 0; i < N; i++) begin
            if (rf_mem[i] !== ref_rf[i]) mism++;
        end
        check("rf_final_mismatches", mism, 0);
        check("timeout_err_random", timeout_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
- Single-issue controller that sequences arithmetic instructions through the execution unit (adder/multiplier pair selected by a 2-bit opcode).
- Buffers incoming instructions in a small FIFO and reads both operands from the register file.
- Drives the execution unit, waits for its ready, then writes the result back to the destination register.
- Sits between the instruction source and the execution unit plus register file; only one operation is in flight at a time.

Parameters:
WIDTH, 8, data width of operands and result
SIZE, 64, register-file entries; AW = $clog2(SIZE) is the address width
DEPTH, 4, instruction FIFO depth (power of two, at least 2)
TIMEOUT, 32, maximum WAIT cycles before an operation is abandoned

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  instruction offered
in_ready  output  1  FIFO can accept (= !full, 0 during reset)
in_opcode  input  2  00 NOP, 01 mul, 10 add, 11 sub
in_dst  input  AW  destination register
in_src1  input  AW  source register 1
in_src2  input  AW  source register 2
rf_raddr1  output  AW  RF read address 1
rf_raddr2  output  AW  RF read address 2
rf_rdata1  input  WIDTH  RF read data 1, valid one cycle after address
rf_rdata2  input  WIDTH  RF read data 2, valid one cycle after address
rf_we  output  1  RF write strobe
rf_waddr  output  AW  RF write address
rf_wdata  output  WIDTH  RF write data
ex_enable  output  1  execution-unit enable
ex_opcode  output  2  opcode to execution unit
ex_src1  output  WIDTH  operand 1
ex_src2  output  WIDTH  operand 2
ex_dst_addr  output  AW  destination forwarded to execution unit
ex_ready  input  1  execution-unit result valid
ex_result  input  WIDTH  execution-unit result
done  output  1  one-cycle pulse per completed writeback
timeout_err  output  1  sticky: some operation timed out
idle  output  1  FSM in IDLE and FIFO empty

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FIFO emptied; FSM goes to IDLE; WAIT counter cleared.
  - All registered outputs go to 0: rf_*, ex_*, done, timeout_err.
  - in_ready=0 while rst_n=0. idle=1 after reset.
  - Reset mid-operation abandons the in-flight instruction: no writeback and no done. ex_enable is 0 from the reset edge onward.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only in IDLE when not empty.
  - Push and pop in the same cycle are both performed and occupancy is unchanged.
  - When full, in_ready=0 and in_valid is ignored.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, READ, ISSUE, WAIT, WRITE.
- IDLE:
  - If FIFO is non-empty, pop the head into the instruction register.
  - opcode 00 is discarded: stay in IDLE, no done.
  - Otherwise go to READ.
- READ:
  - rf_raddr1/2 = latched src1/src2 for this cycle; go to ISSUE.
- ISSUE:
  - Register rf_rdata1/2 into ex_src1/2; set ex_opcode and ex_dst_addr; set ex_enable=1.
  - Clear the WAIT counter; go to WAIT.
- WAIT:
  - ex_enable, ex_src*, ex_opcode and ex_dst_addr are held stable.
  - ex_ready is ignored in the first WAIT cycle, because a stale ready from the previous op may still be high.
  - From the second cycle on, ex_ready=1 captures ex_result, drops ex_enable and goes to WRITE.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT with no ready: set timeout_err, drop ex_enable, go to IDLE with no writeback. An ex_ready arriving in that same cycle is ignored.
- WRITE:
  - rf_we=1 for exactly one cycle, with rf_waddr=dst and rf_wdata=captured result; done=1 in the same cycle.
  - Go to IDLE.
- Minimum latency: head-of-FIFO pop to rf_we is 5 cycles, given ex_ready on the second WAIT cycle.
- Back-to-back: the next pop may occur in the IDLE cycle immediately after WRITE.
- Source equal to destination needs no hazard logic: writeback completes before the next READ.
- Arithmetic is delegated to the execution unit. The sequencer never modifies data; result width is WIDTH and is written unchanged.
- timeout_err clears only on reset.

Test Plan:
- Reset then push add (dst=3, src1=1, src2=2) with R1=5, R2=3; model ex_ready 2 cycles after enable, result=8 -> one rf_we with waddr=3, wdata=8, done pulse, idle=1 afterwards.
- Push 5 instructions while the FSM is stalled in WAIT -> in_ready=0 after the 4th (DEPTH=4); 5th accepted after the first pop; all execute in order with sub opcode 11 forwarded unchanged.
- Push NOP then mul (dst=4, R1=5, R2=3, result=15) -> NOP yields no rf_we and no done; mul writes R4=15.
- Hold ex_ready=0 -> timeout_err=1 after 32 WAIT cycles, no rf_we, FSM in IDLE; next instruction executes normally and timeout_err stays 1.
- ex_ready stuck at 1 entering WAIT -> not accepted in the first WAIT cycle; writeback occurs on the second.
- Assert rst_n=0 during WAIT with 2 entries queued -> no rf_we, FIFO empty, idle=1, in_ready=1 after release.
